dbus_xbar: RTL
==============

Name: dbus_xbar

Overview:
Parametrised data-bus interconnect: one CPU master port fanned out to NS slave regions, decoded by the top BKW address bits.
- Generalises the fixed 4-region data bus: slave count, data/address width and region size are parameters.
- Adds a per-slave ready handshake for wait states, an error response for unmapped regions, a watchdog timeout, and error capture registers.
- Sits between the core's load/store unit and RAM/IO/timer/interrupt-controller slaves.

Parameters:
DW, 16, data width
AW, 16, master address width
BKW, 4, region-select bits taken from addr[AW-1:AW-BKW]
NS, 4, number of slave regions present (1..2^BKW); regions NS..2^BKW-1 are unmapped
TO_CYC, 16, max wait cycles before timeout error; 0 disables timeout (width clog2(TO_CYC+1))

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m_req  in  1  master request valid
m_we  in  1  1 = write, 0 = read
m_addr  in  AW  master address
m_din  in  DW  write data
m_gnt  out  1  request accepted this cycle
m_rdy  out  1  transfer complete (read data/err valid this cycle)
m_dout  out  DW  read data, valid when m_rdy
m_err  out  1  error completion (unmapped or timeout), qualifies m_rdy
s_sel  out  NS  one-hot slave select, one-cycle pulse per access
s_we  out  1  write enable, meaningful when any s_sel bit is set
s_addr  out  AW-BKW  slave-local address
s_din  out  DW  write data to slaves
s_dout  in  NS*DW  flattened slave read data, slave k at [k*DW +: DW]
s_rdy  in  NS  slave k completes the access in this cycle
err_addr  out  AW  address of the most recent errored access
err_cnt  out  8  saturating count of error completions

Behaviour:
- FSM states: IDLE, WAIT, ERR. Reset puts the FSM in IDLE and clears bank register, wait counter, err_addr and err_cnt.
- Reset drives m_gnt=1, m_rdy=0, m_err=0, m_dout=0, s_sel=0.
- m_gnt is combinational:
  - 1 in IDLE;
  - 1 in a WAIT cycle that completes (slave ready or timeout);
  - 1 in ERR;
  - else 0.
- Accept happens when m_req && m_gnt.
  - Decode bk = m_addr[AW-1:AW-BKW].
  - If bk<NS: s_sel[bk]=1 that same cycle (combinational). s_we=m_we, s_addr=m_addr[AW-BKW-1:0], s_din=m_din. Register bk, clear the wait counter, next state WAIT.
  - If bk>=NS: s_sel stays 0. Latch err_addr=m_addr and go to ERR.
- s_sel is 0 in every cycle without an accept. s_addr, s_din and s_we follow the master ports and are don't-care when s_sel=0.
- WAIT:
  - m_rdy = s_rdy[bk]; m_dout = s_dout[bk] when m_rdy, else 0. m_err=0.
  - Wait counter increments each WAIT cycle with s_rdy[bk]=0.
  - If TO_CYC>0 and the counter == TO_CYC-1 with no ready: this cycle m_rdy=1, m_err=1, m_dout=0; latch err_addr from the registered access address; complete.
  - On completion: with a new accept go to the new target, else go to IDLE.
- ERR lasts one cycle: m_rdy=1, m_err=1, m_dout=0. It can accept a new request; if none, go to IDLE.
- Latency:
  - zero-wait slave (s_rdy tied 1, sync BRAM): m_rdy exactly 1 cycle after accept; back-to-back accepts give 1 transfer/cycle;
  - n wait states: n+1 cycles.
  - Writes use the identical handshake; write completion is signalled by s_rdy.
- err_cnt increments on every m_err completion and saturates at 255. Simultaneous error completion and error accept: count +1 now and +1 at the next completion.
- s_rdy from non-selected slaves and s_rdy seen in IDLE/ERR are ignored.
- rst asserted mid-WAIT aborts the transfer. No m_rdy is issued; the next cycle is IDLE with all outputs at reset values.
- m_req while m_gnt=0: the master must hold m_req/m_addr/m_we/m_din stable until accepted.

Decomposition:
- Shared package dbus_pkg holds:
  - localparams for the region map: RAM_BK=0, IO_BK=1, TMR_BK=2, INTC_BK=3;
  - the FSM state encoding: IDLE=2'd0, WAIT=2'd1, ERR=2'd2.
- One natural sub-module: dbus_rd_mux. It is the NS-way read-data/ready selector indexed by the registered bk, and returns zero for out-of-range indices.

Test Plan:
- NS=4, slave0 s_rdy=1, read 0x0005 returning 0x1234 -> s_sel=4'b0001 on the accept cycle; next cycle m_rdy=1, m_dout=0x1234, m_err=0.
- Back-to-back writes to 0x1000 then 0x2003, all s_rdy=1 -> s_sel 0010 then 0100 on consecutive cycles, s_addr 0x000 then 0x003; two m_rdy pulses; m_gnt stays 1.
- Slave2 holds s_rdy=0 for 3 cycles, then 1 with data 0xBEEF -> m_gnt=0 during the wait; m_rdy=1 on cycle 4 after accept with m_dout=0xBEEF.
- Read 0x7ABC (unmapped) -> s_sel stays 0; next cycle m_rdy=1, m_err=1, m_dout=0; err_addr=0x7ABC; err_cnt=1.
- TO_CYC=16, slave3 never ready -> m_rdy=m_err=1 exactly 16 cycles after accept; err_cnt increments; FSM returns to IDLE.
- Assert rst during a WAIT on slave1 -> next cycle m_rdy=0, s_sel=0, err_cnt=0, m_gnt=1; a later s_rdy[1] pulse produces no m_rdy.

Source files
------------

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared definitions for the data-bus interconnect.
//   - Region map of the standard four-slave system (RAM, IO, timer, INTC).
//   - Transfer FSM state encoding used by dbus_xbar.
package dbus_pkg;

  localparam int RAM_BK  = 0;
  localparam int IO_BK   = 1;
  localparam int TMR_BK  = 2;
  localparam int INTC_BK = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/dbus_xbar_if.sv
// dbus_xbar_if: CPU-side and slave-side signals of the data bus.
//   master : CPU load/store unit view (drives request, receives completion)
//   slave  : slave-region view (receives select/address/data, returns data/ready)
//   xbar   : interconnect view (bridges the two sides)
//   Signals: m_req/m_we/m_addr/m_din, m_gnt/m_rdy/m_dout/m_err,
//            s_sel/s_we/s_addr/s_din, s_dout (flattened NS*DW), s_rdy.
interface dbus_xbar_if
  import dbus_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int BKW = 4,
  parameter int NS  = 4
);
  logic              m_req;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_din;
  logic              m_gnt;
  logic              m_rdy;
  logic [DW-1:0]     m_dout;
  logic              m_err;
  logic [NS-1:0]     s_sel;
  logic              s_we;
  logic [AW-BKW-1:0] s_addr;
  logic [DW-1:0]     s_din;
  logic [NS*DW-1:0]  s_dout;
  logic [NS-1:0]     s_rdy;

  modport master (output m_req, m_we, m_addr, m_din,
                  input  m_gnt, m_rdy, m_dout, m_err);

  modport slave  (input  s_sel, s_we, s_addr, s_din,
                  output s_dout, s_rdy);

  modport xbar   (input  m_req, m_we, m_addr, m_din, s_dout, s_rdy,
                  output m_gnt, m_rdy, m_dout, m_err, s_sel, s_we, s_addr, s_din);
endinterface

// File: rtl/dbus_rd_mux.sv
// dbus_rd_mux: NS-way read-data / ready selector.
//   idx_i  : registered region index
//   dout_i : flattened slave read data, slave k at [k*DW +: DW]
//   rdy_i  : per-slave ready
//   dout_o / rdy_o : selected slave's data / ready; zero for idx_i >= NS
module dbus_rd_mux
  import dbus_pkg::*;
#(
  parameter int DW  = 16,
  parameter int BKW = 4,
  parameter int NS  = 4
) (
  input  logic [BKW-1:0]   idx_i,
  input  logic [NS*DW-1:0] dout_i,
  input  logic [NS-1:0]    rdy_i,
  output logic [DW-1:0]    dout_o,
  output logic             rdy_o
);

  always_comb begin
    dout_o = '0;
    rdy_o  = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (int'(idx_i) == k) begin
        dout_o = dout_i[k*DW +: DW];
        rdy_o  = rdy_i[k];
      end
    end
  end

endmodule

// File: rtl/dbus_xbar.sv
// dbus_xbar: one CPU master fanned out to NS slave regions selected by
// m_addr[AW-1:AW-BKW]. Slaves complete with s_rdy (wait states allowed);
// unmapped regions and watchdog expiry complete with m_err.
//   clk, rst     : clock, synchronous active-high reset
//   bus (xbar)   : master request/completion and slave select/data signals
//   err_addr     : address of the most recent errored access
//   err_cnt      : saturating count of error completions
module dbus_xbar
  import dbus_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int BKW    = 4,
  parameter int NS     = 4,
  parameter int TO_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  dbus_xbar_if.xbar     bus,
  output logic [AW-1:0] err_addr,
  output logic [7:0]    err_cnt
);

  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

  state_e         state_q, state_d;
  logic [BKW-1:0] bk_q, bk_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [BKW-1:0] req_bk;
  logic           req_mapped;
  logic           accept;
  logic           gnt, rdy, err;
  logic [DW-1:0]  dout;
  logic           sel_rdy;
  logic [DW-1:0]  sel_dout;
  logic           timeout;
  logic [NS-1:0]  sel;

  assign req_bk     = bus.m_addr[AW-1:AW-BKW];
  assign req_mapped = int'(req_bk) < NS;

  dbus_rd_mux #(.DW(DW), .BKW(BKW), .NS(NS)) u_rd_mux (
    .idx_i  (bk_q),
    .dout_i (bus.s_dout),
    .rdy_i  (bus.s_rdy),
    .dout_o (sel_dout),
    .rdy_o  (sel_rdy)
  );

  // Ready on the same cycle as expiry wins: the slave's data is delivered.
  assign timeout = (TO_CYC > 0) && (state_q == WAIT) && !sel_rdy &&
                   (cnt_q == CW'(TO_CYC - 1));

  always_comb begin
    state_d    = state_q;
    bk_d       = bk_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    gnt        = 1'b1;
    rdy        = 1'b0;
    err        = 1'b0;
    dout       = '0;
    accept     = 1'b0;

    unique case (state_q)
      IDLE: ;
      WAIT: begin
        if (sel_rdy) begin
          rdy     = 1'b1;
          dout    = sel_dout;
          state_d = IDLE;
        end else if (timeout) begin
          rdy        = 1'b1;
          err        = 1'b1;
          err_addr_d = addr_q;
          state_d    = IDLE;
        end else begin
          gnt   = 1'b0;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERR: begin
        rdy     = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset cycles present the idle face and take no request.
    if (rst) begin
      gnt  = 1'b1;
      rdy  = 1'b0;
      err  = 1'b0;
      dout = '0;
    end

    accept = bus.m_req && gnt && !rst;

    if (accept) begin
      addr_d = bus.m_addr;
      if (req_mapped) begin
        state_d = WAIT;
        bk_d    = req_bk;
        cnt_d   = '0;
      end else begin
        state_d    = ERR;
        err_addr_d = bus.m_addr;
      end
    end

    if (err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < NS; k++) begin
      if (accept && req_mapped && (int'(req_bk) == k)) sel[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bk_q       <= '0;
      cnt_q      <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bk_q       <= bk_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign bus.m_gnt  = gnt;
  assign bus.m_rdy  = rdy;
  assign bus.m_err  = err;
  assign bus.m_dout = dout;
  assign bus.s_sel  = sel;
  assign bus.s_we   = bus.m_we;
  assign bus.s_addr = bus.m_addr[AW-BKW-1:0];
  assign bus.s_din  = bus.m_din;
  assign err_addr   = err_addr_q;
  assign err_cnt    = err_cnt_q;

endmodule
